// File: rtl/dense_weight_streamer_pkg.sv
// Shared types for the dense-layer weight streamer.
//   ShiftBits           : width of the output shift amount
//   dense_stream_state_e: sequencer states
//   weight_vec_t        : one weight vector at the default lane geometry
package dense_pkg;
  localparam int ShiftBits   = 6;
  localparam int WeightN     = 16;
  localparam int WeightLanes = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } dense_stream_state_e;

  typedef logic signed [WeightLanes-1:0][WeightN-1:0] weight_vec_t;
endpackage

// File: rtl/dense_weight_streamer_if.sv
// Job, weight-memory and dense-layer stream signals of the weight streamer.
//   slave  : seen from the streamer (job/mem data/ready in, reads/beats out)
//   master : seen from the surroundings (job source, memory, dense layer)
interface dense_weight_streamer_if #(
  parameter int N           = 16,
  parameter int EngineCount = 4,
  parameter int AddrBits    = 12,
  parameter int LenBits     = 12
);
  import dense_pkg::*;

  logic                                 start_i;
  logic [AddrBits-1:0]                  base_addr_i;
  logic [LenBits-1:0]                   length_i;
  logic                                 accum_i;
  logic [ShiftBits-1:0]                 shift_i;
  logic                                 mem_rd_o;
  logic [AddrBits-1:0]                  mem_addr_o;
  logic [EngineCount-1:0][N-1:0]        mem_data_i;
  logic                                 ready_i;
  logic                                 en_o;
  logic signed [EngineCount-1:0][N-1:0] weight_o;
  logic                                 last_o;
  logic                                 accum_o;
  logic [ShiftBits-1:0]                 shift_o;
  logic                                 busy_o;
  logic                                 done_o;

  modport slave (
    input  start_i, base_addr_i, length_i, accum_i, shift_i, mem_data_i, ready_i,
    output mem_rd_o, mem_addr_o, en_o, weight_o, last_o, accum_o, shift_o,
           busy_o, done_o
  );

  modport master (
    output start_i, base_addr_i, length_i, accum_i, shift_i, mem_data_i, ready_i,
    input  mem_rd_o, mem_addr_o, en_o, weight_o, last_o, accum_o, shift_o,
           busy_o, done_o
  );
endinterface

// File: rtl/dense_weight_streamer_skid_fifo.sv
// weight_skid_fifo: 2-entry register FIFO absorbing the memory read latency
// under downstream backpressure.
//   clk_i, rst_i : clock, async active-high reset
//   push_i/data_i: write a word (accepted when not full, or full with a pop)
//   pop_i        : drop the head (ignored when empty)
//   data_o       : head word
//   full_o, valid_o, count_o : occupancy status
module weight_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [1:0][W-1:0] r_mem;
  logic              r_wp, r_rp;
  logic [1:0]        r_count;
  logic              w_push, w_pop;

  assign valid_o = (r_count != 2'd0);
  assign full_o  = (r_count == 2'd2);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rp];

  // A full FIFO may still take a word in the same cycle its head leaves.
  assign w_pop  = pop_i & valid_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem   <= '0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= data_i;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dense_weight_streamer.sv
// dense_weight_streamer: reads a run of weight vectors from a synchronous
// weight memory and streams them to the dense layer one beat per cycle,
// with the job's accumulate mode and shift amount.
//   clk_i, rst_i : clock, async active-high reset
//   bus.start_i, base_addr_i, length_i, accum_i, shift_i : job request
//   bus.mem_rd_o, mem_addr_o, mem_data_i : weight memory (1-cycle latency)
//   bus.ready_i, en_o, weight_o, last_o, accum_o, shift_o : dense layer side
//   bus.busy_o, done_o : job status
module dense_weight_streamer
  import dense_pkg::*;
#(
  parameter int N           = 16,
  parameter int EngineCount = 4,
  parameter int AddrBits    = 12,
  parameter int LenBits     = 12
) (
  input logic clk_i,
  input logic rst_i,
  dense_weight_streamer_if.slave bus
);
  localparam int W = N * EngineCount;

  dense_stream_state_e  r_state;
  logic [AddrBits-1:0]  r_base;
  logic [LenBits-1:0]   r_len, r_issued, r_sent;
  logic                 r_accum;
  logic [ShiftBits-1:0] r_shift;
  logic                 r_inflight;

  logic         w_valid, w_full, w_en, w_last, w_rd;
  logic [1:0]   w_count;
  logic [2:0]   w_eff;
  logic [W-1:0] w_head;

  weight_skid_fifo #(.W(W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (r_inflight),
    .pop_i   (w_en),
    .data_i  (bus.mem_data_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .valid_o (w_valid),
    .count_o (w_count)
  );

  assign w_en   = w_valid & bus.ready_i;
  assign w_last = w_valid & (r_sent == r_len - LenBits'(1));

  // Occupancy after this cycle's pop plus the read already in flight; a
  // read is issued only if its data is guaranteed a FIFO slot on arrival.
  // Counting the pop lets a full-rate stream keep one read per cycle.
  assign w_eff = {1'b0, w_count} - {2'b0, w_en} + {2'b0, r_inflight};
  assign w_rd  = (r_state == ST_STREAM) && (r_issued < r_len) &&
                 (w_eff < 3'd2) && (~w_full | w_en);

  assign bus.mem_rd_o   = w_rd;
  assign bus.mem_addr_o = r_base + AddrBits'(r_issued);  // wraps naturally
  assign bus.en_o       = w_en;
  assign bus.weight_o   = w_valid ? w_head : '0;
  assign bus.last_o     = w_last;
  assign bus.accum_o    = r_accum;
  assign bus.shift_o    = r_shift;
  assign bus.busy_o     = (r_state == ST_STREAM);
  assign bus.done_o     = (r_state == ST_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_accum    <= 1'b0;
      r_shift    <= '0;
      r_inflight <= 1'b0;   // drops any response still in the memory pipe
    end else begin
      r_inflight <= w_rd;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_base   <= bus.base_addr_i;
            r_len    <= bus.length_i;
            r_accum  <= bus.accum_i;
            r_shift  <= bus.shift_i;
            r_issued <= '0;
            r_sent   <= '0;
            r_state  <= (bus.length_i == '0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_rd) r_issued <= r_issued + LenBits'(1);
          if (w_en) r_sent   <= r_sent + LenBits'(1);
          if (w_en && w_last) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_weight_streamer.sv
module tb_dense_weight_streamer;
  import dense_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_weight_streamer_if #(.N(16), .EngineCount(4), .AddrBits(12), .LenBits(12)) intf ();

  dense_weight_streamer #(.N(16), .EngineCount(4), .AddrBits(12), .LenBits(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (intf.slave)
  );

  typedef struct {
    logic [63:0] w;
    logic        last;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  beat_t        exp_q[$];
  logic [11:0]  exp_rd_q[$];
  logic         exp_acc;
  logic [5:0]   exp_sh;
  int n_rd, n_en, first_rd, last_rd, first_en, last_rel, done_rel;
  bit done_seen;

  // Memory contents: lane0 = address, other lanes derived from it.
  function automatic logic [63:0] memword(input logic [11:0] a);
    logic [15:0] l0, l1, l2, l3;
    l0 = {4'h0, a};
    l1 = 16'(a) * 16'd7 + 16'h1234;
    l2 = {a, 4'hA};
    l3 = ~{4'h0, a};
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight memory model.
  always @(posedge clk) intf.mem_data_i <= memword(intf.mem_addr_o);

  task automatic check_zero(input string tag);
    chk({tag, "_en"},    64'(intf.en_o),       0);
    chk({tag, "_rd"},    64'(intf.mem_rd_o),   0);
    chk({tag, "_addr"},  64'(intf.mem_addr_o), 0);
    chk({tag, "_w"},     64'(intf.weight_o),   0);
    chk({tag, "_last"},  64'(intf.last_o),     0);
    chk({tag, "_acc"},   64'(intf.accum_o),    0);
    chk({tag, "_sh"},    64'(intf.shift_o),    0);
    chk({tag, "_busy"},  64'(intf.busy_o),     0);
    chk({tag, "_done"},  64'(intf.done_o),     0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or a beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (intf.en_o) begin
        n_en++;
        if (first_en < 0) first_en = cyc - t0;
        if (intf.last_o) last_rel = cyc - t0;
        if (exp_q.size() == 0) chk("en_extra", 1, 0);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("weight", 64'(intf.weight_o), b.w);
          chk("last",   64'(intf.last_o),   64'(b.last));
          chk("accum",  64'(intf.accum_o),  64'(exp_acc));
          chk("shift",  64'(intf.shift_o),  64'(exp_sh));
        end
      end
      if (intf.mem_rd_o) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc - t0;
        last_rd = cyc - t0;
        if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", 64'(intf.mem_addr_o), 64'(exp_rd_q.pop_front()));
        chk("outstanding_le2", 64'((n_rd - n_en) <= 2), 1);
      end
      if (intf.done_o) begin
        done_seen = 1;
        done_rel  = cyc - t0;
      end
    end
  end

  // mode: 0 ready high, 1 ready low in cycles 4..6, 2 random ready,
  //       3 ready high + ignored start at cycle 2, 4 reset at cycle 4
  task automatic run_job(input logic [11:0] base, input int len, input logic acc,
                         input logic [5:0] sh, input int mode);
    int  rel;
    bit  aborted;
    aborted = 0;
    n_rd = 0; n_en = 0; first_rd = -1; last_rd = -1; first_en = -1;
    last_rel = -1; done_rel = -1; done_seen = 0;
    exp_acc = acc; exp_sh = sh;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      logic [11:0] a;
      a = base + 12'(i);
      b.w = memword(a);
      b.last = (i == len - 1);
      exp_q.push_back(b);
      exp_rd_q.push_back(a);
    end
    @(posedge clk); #1;
    t0 = cyc;
    intf.start_i = 1; intf.base_addr_i = base; intf.length_i = 12'(len);
    intf.accum_i = acc; intf.shift_i = sh;
    intf.ready_i = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int k = 0; k < 60 + 8 * len && !done_seen && !aborted; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      intf.start_i = 0;
      case (mode)
        1: intf.ready_i = !(rel >= 4 && rel <= 6);
        2: intf.ready_i = ($urandom_range(0, 3) != 0);
        3: if (rel == 2) begin
             intf.start_i = 1; intf.base_addr_i = 12'hABC; intf.length_i = 12'd9;
             intf.accum_i = ~acc; intf.shift_i = ~sh;
           end
        4: if (rel == 4) begin
             rst = 1;
             @(negedge clk);
             check_zero("rst_mid");
             @(posedge clk); #1;
             rst = 0;
             exp_q.delete();
             exp_rd_q.delete();
             aborted = 1;
           end
        default: intf.ready_i = 1'b1;
      endcase
    end
    if (aborted) return;
    chk("done_seen", 64'(done_seen), 1);
    chk("beats", 64'(n_en), 64'(len));
    chk("reads", 64'(n_rd), 64'(len));
    chk("sb_empty", 64'(exp_q.size() + exp_rd_q.size()), 0);
    if (len == 0) chk("done_cyc_len0", 64'(done_rel), 1);
    else if (mode == 0 || mode == 3) begin
      chk("first_rd_cyc", 64'(first_rd), 1);
      chk("last_rd_cyc",  64'(last_rd),  64'(len));
      chk("first_en_cyc", 64'(first_en), 3);
      chk("last_cyc",     64'(last_rel), 64'(len + 2));
      chk("done_cyc",     64'(done_rel), 64'(len + 3));
    end else if (mode == 1) begin
      chk("stall_done_cyc", 64'(done_rel), 64'(len + 6));
    end
  endtask

  initial begin
    intf.start_i = 0; intf.base_addr_i = '0; intf.length_i = '0;
    intf.accum_i = 0; intf.shift_i = '0; intf.ready_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst_init");
    @(posedge clk); #1;
    rst = 0;

    run_job(12'h010, 4, 1'b0, 6'd8, 0);
    run_job(12'h120, 6, 1'b1, 6'd3, 1);
    run_job(12'h100, 0, 1'b0, 6'd5, 0);
    run_job(12'hFFE, 3, 1'b1, 6'd12, 0);
    run_job(12'h200, 5, 1'b0, 6'd8, 3);
    run_job(12'h300, 8, 1'b1, 6'd1, 4);
    run_job(12'h400, 2, 1'b1, 6'd2, 0);
    for (int j = 0; j < 8; j++)
      run_job(12'($urandom), $urandom_range(1, 20), 1'($urandom), 6'($urandom), 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
